// File: rtl/key_pio_poller_if.sv
// Avalon-MM read-only link between the keypad poller and the PIO slave.
// The poller owns address/read; the slave owns waitrequest/readdata.
interface key_pio_poller_if;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );
endinterface

// File: rtl/key_pio_poller.sv
// Periodic keypad PIO poller with per-key debounce.
// Publishes debounced key levels plus press/release pulses.
module key_pio_poller #(
    parameter int         NKEYS        = 2,
    parameter int         POLL_DIV     = 50000,
    parameter int         READ_LATENCY = 1,
    parameter int         DEBOUNCE_CNT = 4,
    parameter int         ACTIVE_LOW   = 1,
    parameter logic [1:0] DATA_ADDR    = 2'd0
) (
    input  logic              clk,
    input  logic              reset_n,
    key_pio_poller_if.master  avm,
    output logic [NKEYS-1:0]  key_state,
    output logic [NKEYS-1:0]  key_press,
    output logic [NKEYS-1:0]  key_release,
    output logic              sample_valid
);
    localparam int TW = $clog2(POLL_DIV + 1);
    localparam int LW = $clog2(READ_LATENCY + 1);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(POLL_DIV - 1);
    localparam logic [LW-1:0] LAT_INIT =
        LW'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
    localparam logic [CW-1:0] CNT_TOP = CW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        CAPT
    } state_t;

    state_t            state;
    logic [TW-1:0]     timer;
    logic [LW-1:0]     lat;
    logic [CW-1:0]     cnt [NKEYS];
    logic              tick;
    logic [NKEYS-1:0]  raw;
    logic              unused_hi;

    assign tick = (timer == '0);
    assign avm.avm_address = DATA_ADDR;
    assign raw = (ACTIVE_LOW != 0) ? ~avm.avm_readdata[NKEYS-1:0]
                                   :  avm.avm_readdata[NKEYS-1:0];
    assign unused_hi = ^avm.avm_readdata[31:NKEYS];

    // Free-running poll timer; tick fires when it hits zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer <= TIMER_RELOAD;
        end else if (tick) begin
            timer <= TIMER_RELOAD;
        end else begin
            timer <= timer - 1'b1;
        end
    end

    // Read FSM: one outstanding read, ticks outside IDLE are dropped.
    // Accept lands in CAPT exactly READ_LATENCY cycles later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            avm.avm_read <= 1'b0;
            lat          <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (tick) begin
                        state        <= REQ;
                        avm.avm_read <= 1'b1;
                    end
                end
                REQ: begin
                    if (!avm.avm_waitrequest) begin
                        avm.avm_read <= 1'b0;
                        if (READ_LATENCY == 1) begin
                            state        <= CAPT;
                            sample_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                            lat   <= LAT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (lat == '0) begin
                        state        <= CAPT;
                        sample_valid <= 1'b1;
                    end else begin
                        lat <= lat - 1'b1;
                    end
                end
                CAPT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Per-key debounce; state flips after DEBOUNCE_CNT differing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_state   <= '0;
            key_press   <= '0;
            key_release <= '0;
            for (int k = 0; k < NKEYS; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            key_press   <= '0;
            key_release <= '0;
            if (state == CAPT) begin
                for (int k = 0; k < NKEYS; k++) begin
                    if (raw[k] == key_state[k]) begin
                        cnt[k] <= '0;
                    end else if (cnt[k] == CNT_TOP) begin
                        cnt[k]       <= '0;
                        key_state[k] <= ~key_state[k];
                        if (key_state[k]) begin
                            key_release[k] <= 1'b1;
                        end else begin
                            key_press[k] <= 1'b1;
                        end
                    end else begin
                        cnt[k] <= cnt[k] + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_key_pio_poller.sv
// Bench for key_pio_poller: slave model, debounce scoreboard,
// and scenario tasks for reset, press, bounce, stalls and release.
module tb_key_pio_poller;
    localparam int PD = 8;
    localparam int RL = 1;
    localparam int DB = 3;

    typedef struct packed {
        logic [1:0] st;
        logic [1:0] pr;
        logic [1:0] rl;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] key_state;
    logic [1:0] key_press;
    logic [1:0] key_release;
    logic       sample_valid;

    key_pio_poller_if avm();

    key_pio_poller #(
        .NKEYS(2),
        .POLL_DIV(PD),
        .READ_LATENCY(RL),
        .DEBOUNCE_CNT(DB),
        .ACTIVE_LOW(1),
        .DATA_ADDR(2'd0)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .avm(avm),
        .key_state(key_state),
        .key_press(key_press),
        .key_release(key_release),
        .sample_valid(sample_valid)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [31:0] cur_word = 32'h3;
    int         cyc = 0;
    int         acc_cyc = 0;
    int         outstanding = 0;
    int         n_acc = 0;
    int         n_sv = 0;
    obs_t       exp_q[$];
    obs_t       obs_q[$];
    logic [1:0] m_state;
    logic [1:0] m_raw;
    logic [1:0] m_pr;
    logic [1:0] m_rl;
    int         m_cnt[2];
    logic       sv_d = 1'b0;
    logic       prev_read = 1'b0;

    // Slave model and debounce reference, evaluated on each accept.
    always @(posedge clk) begin
        if (!reset_n) begin
            cyc = 0;
            outstanding = 0;
            m_state = 2'b00;
            m_cnt[0] = 0;
            m_cnt[1] = 0;
            avm.avm_readdata <= '0;
        end else begin
            cyc++;
            if (avm.avm_read && !avm.avm_waitrequest) begin
                checks++;
                if (outstanding != 0) begin
                    errors++;
                    $display("FAIL outstanding got %0d want 0", outstanding);
                end
                outstanding++;
                n_acc++;
                acc_cyc = cyc;
                avm.avm_readdata <= cur_word;
                m_raw = ~cur_word[1:0];
                m_pr = 2'b00;
                m_rl = 2'b00;
                for (int k = 0; k < 2; k++) begin
                    if (m_raw[k] == m_state[k]) begin
                        m_cnt[k] = 0;
                    end else if (m_cnt[k] == DB - 1) begin
                        if (m_state[k]) m_rl[k] = 1'b1;
                        else m_pr[k] = 1'b1;
                        m_state[k] = ~m_state[k];
                        m_cnt[k] = 0;
                    end else begin
                        m_cnt[k]++;
                    end
                end
                exp_q.push_back({m_state, m_pr, m_rl});
            end
        end
    end

    // Monitor: collects post-capture outputs, checks pulses, latency, phase.
    always @(negedge clk) begin
        if (!reset_n) begin
            sv_d = 1'b0;
            prev_read = 1'b0;
        end else begin
            if (sv_d) begin
                obs_q.push_back({key_state, key_press, key_release});
            end else begin
                checks++;
                if ((key_press | key_release) !== 2'b00) begin
                    errors++;
                    $display("FAIL spurious_pulse got pr=%b rl=%b want 00",
                             key_press, key_release);
                end
            end
            if (sample_valid) begin
                n_sv++;
                checks++;
                if (outstanding != 1 || cyc - acc_cyc + 1 != RL) begin
                    errors++;
                    $display("FAIL capture_latency got out=%0d lat=%0d want 1/%0d",
                             outstanding, cyc - acc_cyc + 1, RL);
                end
                outstanding = 0;
            end
            if (avm.avm_read && !prev_read) begin
                checks++;
                if (cyc % PD != 0) begin
                    errors++;
                    $display("FAIL poll_phase got cyc=%0d want multiple of %0d",
                             cyc, PD);
                end
            end
            prev_read = avm.avm_read;
            sv_d = sample_valid;
        end
    end

    task automatic wait_obs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (obs_q.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic sync_poll();
        bit ok;
        wait_obs(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL sync_timeout got none want capture");
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        int n;
        avm.avm_waitrequest = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({avm.avm_read, key_state, key_press, key_release, sample_valid} !== 8'h0
            || avm.avm_address !== 2'd0) begin
            errors++;
            $display("FAIL reset_values got rd=%b st=%b addr=%0d want 0",
                     avm.avm_read, key_state, avm.avm_address);
        end
        reset_n = 1'b1;
        avm.avm_waitrequest = 1'b1;
        n = 0;
        while (avm.avm_read !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (avm.avm_read !== 1'b1) begin
            errors++;
            $display("FAIL reset_req got rd=%b want 1", avm.avm_read);
        end
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({avm.avm_read, key_state, key_press, key_release, sample_valid} !== 8'h0) begin
            errors++;
            $display("FAIL reset_async got rd=%b sv=%b want 0",
                     avm.avm_read, sample_valid);
        end
        avm.avm_waitrequest = 1'b0;
        repeat (2) @(negedge clk);
        obs_q.delete();
        exp_q.delete();
        reset_n = 1'b1;
        n = 0;
        while (avm.avm_read !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != PD) begin
            errors++;
            $display("FAIL reset_first_poll got %0d want %0d", n, PD);
        end
    endtask

    task automatic test_press();
        bit   ok;
        obs_t o;
        obs_t e;
        obs_t hist[3];
        sync_poll();
        cur_word = 32'h5A5A_0002;
        for (int i = 0; i < 3; i++) begin
            wait_obs(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL press_timeout poll %0d got none want capture", i);
                hist[i] = '0;
            end else begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                hist[i] = o;
                if (o !== e) begin
                    errors++;
                    $display("FAIL press poll %0d got %b want %b", i, o, e);
                end
            end
        end
        checks++;
        if (hist[0].pr !== 2'b00 || hist[1].pr !== 2'b00
            || hist[2].pr !== 2'b01 || hist[2].st !== 2'b01) begin
            errors++;
            $display("FAIL press_final got pr=%b st=%b want 01/01",
                     hist[2].pr, hist[2].st);
        end
    endtask

    task automatic test_release_both();
        bit   ok;
        obs_t o;
        obs_t e;
        obs_t hist[6];
        sync_poll();
        cur_word = 32'hA5A5_A5A4;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) cur_word = 32'h5A5A_5A5B;
            wait_obs(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL release_timeout poll %0d got none want capture", i);
                hist[i] = '0;
            end else begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                hist[i] = o;
                if (o !== e) begin
                    errors++;
                    $display("FAIL release poll %0d got %b want %b", i, o, e);
                end
            end
        end
        checks++;
        if (hist[2].st !== 2'b11 || hist[4].rl !== 2'b00
            || hist[5].rl !== 2'b11 || hist[5].st !== 2'b00) begin
            errors++;
            $display("FAIL release_final got st=%b rl=%b want 00/11",
                     hist[5].st, hist[5].rl);
        end
    endtask

    task automatic test_bounce();
        bit          ok;
        obs_t        o;
        obs_t        e;
        obs_t        hist[5];
        int          presses;
        logic [31:0] seq[5];
        seq[0] = 32'hFFFF_FFF2;
        seq[1] = 32'hFFFF_FFF3;
        seq[2] = 32'hFFFF_FFF2;
        seq[3] = 32'hFFFF_FFF2;
        seq[4] = 32'hFFFF_FFF2;
        presses = 0;
        sync_poll();
        for (int i = 0; i < 5; i++) begin
            cur_word = seq[i];
            wait_obs(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL bounce_timeout poll %0d got none want capture", i);
                hist[i] = '0;
            end else begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                hist[i] = o;
                if (o.pr[0]) presses++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL bounce poll %0d got %b want %b", i, o, e);
                end
            end
        end
        checks++;
        if (presses != 1 || hist[3].st[0] !== 1'b0 || hist[4].st[0] !== 1'b1) begin
            errors++;
            $display("FAIL bounce_final got presses=%0d st3=%b st4=%b want 1/0/1",
                     presses, hist[3].st[0], hist[4].st[0]);
        end
    endtask

    task automatic test_waitrequest();
        bit   ok;
        obs_t o;
        obs_t e;
        int   n;
        sync_poll();
        cur_word = 32'h0000_0001;
        avm.avm_waitrequest = 1'b1;
        n = 0;
        while (avm.avm_read !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (avm.avm_read !== 1'b1 || avm.avm_address !== 2'd0) begin
                errors++;
                $display("FAIL stall_hold cyc %0d got rd=%b addr=%0d want 1/0",
                         i, avm.avm_read, avm.avm_address);
            end
        end
        avm.avm_waitrequest = 1'b0;
        wait_obs(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stall_timeout got none want capture");
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            if (o !== e) begin
                errors++;
                $display("FAIL stall_capture got %b want %b", o, e);
            end
        end
    endtask

    task automatic test_overrun();
        bit   ok;
        obs_t o;
        obs_t e;
        int   a0;
        int   s0;
        int   n;
        sync_poll();
        a0 = n_acc;
        s0 = n_sv;
        cur_word = 32'h0000_0003;
        for (int r = 0; r < 3; r++) begin
            avm.avm_waitrequest = 1'b1;
            n = 0;
            while (avm.avm_read !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            repeat (12) @(negedge clk);
            avm.avm_waitrequest = 1'b0;
            wait_obs(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL overrun_timeout round %0d got none want capture", r);
            end else begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL overrun round %0d got %b want %b", r, o, e);
                end
            end
        end
        checks++;
        if (n_acc - a0 != 3 || n_sv - s0 != 3) begin
            errors++;
            $display("FAIL overrun_count got acc=%0d sv=%0d want 3/3",
                     n_acc - a0, n_sv - s0);
        end
    endtask

    initial begin
        avm.avm_waitrequest = 1'b0;
        test_reset();
        test_press();
        test_release_both();
        test_bounce();
        test_waitrequest();
        test_overrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
